mvau_weight_loader: RTL

// - Write-side counterpart of the MVAU weight-memory address generator: fills the weight memory that the control block reads.
// - Accepts a narrow AXI-Stream of weights, packs IN_BW-bit beats into PE*SIMD*TW-bit memory words.
// - Issues sequential write addresses 0..WMEM_DEPTH-1 and flags when the memory holds a complete weight set.
// - Sits between the host/DMA weight stream and the MVAU weight memory write port.

---
 rtl/mvau_weight_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mvau_weight_loader.sv
// MVAU weight loader: packs a narrow weight stream into memory words.
// Optional s_wlast checking is enabled by defining MVAU_WLOAD_TLAST_CHK_EN.
module mvau_weight_loader #(
  parameter int PE           = 2,
  parameter int SIMD         = 2,
  parameter int TW           = 4,
  parameter int IN_BW        = 8,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 2
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      start,
  input  logic [IN_BW-1:0]          s_wdata,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  input  logic                      s_wlast,
  output logic [PE*SIMD*TW-1:0]     wmem_wdata,
  output logic [WMEM_ADDR_BW-1:0]   wmem_waddr,
  output logic                      wmem_we,
  output logic                      load_busy,
  output logic                      load_done,
  output logic                      err_last
);

  localparam int WORD_BW = PE * SIMD * TW;
  localparam int BEATS   = WORD_BW / IN_BW;
  localparam int BCW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [BCW-1:0]          r_beat;
  logic [WMEM_ADDR_BW-1:0] r_word;
  logic [WORD_BW-1:0]      r_pack;
  logic [WORD_BW-1:0]      r_wdata;
  logic [WMEM_ADDR_BW-1:0] r_waddr;
  logic                    r_we;
  logic                    r_done;
  logic                    r_err;

  logic [WORD_BW-1:0]      w_word;
  logic                    w_acc;
  logic                    w_last_beat;
  logic                    w_last_word;
  logic                    w_start_ok;

  assign w_acc       = s_wvalid && (r_state == S_LOAD);
  assign w_last_beat = (r_beat == BCW'(BEATS - 1));
  assign w_last_word = (r_word == WMEM_ADDR_BW'(WMEM_DEPTH - 1));

  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    s_wready   = 1'b0;
    load_busy  = 1'b0;
    w_start_ok = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next     = S_LOAD;
          w_start_ok = 1'b1;
        end
      end
      S_LOAD: begin
        s_wready  = 1'b1;
        load_busy = 1'b1;
        if (w_acc && w_last_beat && w_last_word)
          w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Beat k of a word lands at bits [k*IN_BW +: IN_BW].
  always_comb begin
    w_word = r_pack;
    for (int k = 0; k < BEATS; k++) begin
      if (r_beat == BCW'(k))
        w_word[k*IN_BW +: IN_BW] = s_wdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_beat  <= '0;
      r_word  <= '0;
      r_pack  <= '0;
      r_wdata <= '0;
      r_waddr <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_start_ok) begin
        r_beat <= '0;
        r_word <= '0;
        r_done <= 1'b0;
      end
      if (w_acc) begin
        r_pack <= w_word;
        if (w_last_beat) begin
          r_beat  <= '0;
          r_we    <= 1'b1;
          r_wdata <= w_word;
          r_waddr <= r_word;
          if (w_last_word) begin
            r_word <= '0;
            r_done <= 1'b1;
          end else begin
            r_word <= r_word + 1'b1;
          end
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
    end
  end

`ifdef MVAU_WLOAD_TLAST_CHK_EN
  always_ff @(posedge aclk) begin
    if (!aresetn)
      r_err <= 1'b0;
    else if (w_start_ok)
      r_err <= 1'b0;
    else if (w_acc && (s_wlast != (w_last_beat && w_last_word)))
      r_err <= 1'b1;
  end
`else
  logic w_unused_last;
  assign w_unused_last = s_wlast;
  assign r_err         = 1'b0;
`endif

  assign wmem_wdata = r_wdata;
  assign wmem_waddr = r_waddr;
  assign wmem_we    = r_we;
  assign load_done  = r_done;
  assign err_last   = r_err;

endmodule
